// File: rtl/uart_apb_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_transmitter
// Purpose  : APB slave UART transmitter. Each accepted APB write loads one
//            byte into a holding register. The byte is then sent on tx_serial
//            as an 8N1 frame (start bit, 8 data bits LSB first, stop bit).
//            Because the holding register sits in front of the shift
//            register, back-to-back frames go out with no idle gap.
// Ports    : PCLK, PRESET        - clock, synchronous active-high reset
//            PSEL1, PENABLE,     - APB slave interface. Only PADDR[7] is
//            PWRITE, PADDR,        decoded, and it must be 1. PREADY is low
//            PWDATA, PREADY        while a byte is still pending.
//            tx_serial           - serial line, idles high
//            tx_busy             - frame in progress or byte pending
//            tx_done             - one-cycle pulse at end of each stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_transmitter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL1,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic       PREADY,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [15:0] c_CNT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state,      w_state_nx;
    logic [7:0]  r_hold_data,  w_hold_data_nx;
    logic        r_hold_valid, w_hold_valid_nx;
    logic [7:0]  r_shift,      w_shift_nx;
    logic [15:0] r_cnt,        w_cnt_nx;
    logic [2:0]  r_bit_idx,    w_bit_idx_nx;
    logic        r_tx,         w_tx_nx;
    logic        r_done,       w_done_nx;

    logic        w_wr_acc;
    logic        w_bit_end;
    logic        w_unused;

    // Only bit 7 of the address takes part in decode.
    assign w_unused  = ^PADDR[6:0];

    // A write can only be accepted while the holding register is empty.
    // The FSM only loads from the register while it is full. So an accept
    // and a load can never happen on the same edge.
    assign w_wr_acc  = PSEL1 & PENABLE & PWRITE & PADDR[7] & ~r_hold_valid;
    assign w_bit_end = (r_cnt == c_CNT_LAST);

    assign PREADY    = ~r_hold_valid;
    assign tx_serial = r_tx;
    assign tx_busy   = (r_state != ST_IDLE) | r_hold_valid;
    assign tx_done   = r_done;

    always_comb begin
        w_state_nx      = r_state;
        w_hold_data_nx  = r_hold_data;
        w_hold_valid_nx = r_hold_valid;
        w_shift_nx      = r_shift;
        w_cnt_nx        = r_cnt;
        w_bit_idx_nx    = r_bit_idx;
        w_tx_nx         = r_tx;
        w_done_nx       = 1'b0;

        if (w_wr_acc) begin
            w_hold_data_nx  = PWDATA;
            w_hold_valid_nx = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nx = 1'b1;
                if (r_hold_valid) begin
                    w_shift_nx      = r_hold_data;
                    w_hold_valid_nx = 1'b0;
                    w_cnt_nx        = '0;
                    w_tx_nx         = 1'b0;
                    w_state_nx      = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_cnt_nx     = '0;
                    w_bit_idx_nx = '0;
                    w_tx_nx      = r_shift[0];
                    w_state_nx   = ST_DATA;
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_bit_idx != 3'd7) begin
                        // The shift register moves right so that the next
                        // data bit is always in position 1.
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                        w_tx_nx      = r_shift[1];
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                    end else begin
                        w_tx_nx    = 1'b1;
                        w_state_nx = ST_STOP;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nx  = '0;
                    w_done_nx = 1'b1;
                    if (r_hold_valid) begin
                        // A byte is pending, so go straight into the next
                        // start bit with no idle cycle.
                        w_shift_nx      = r_hold_data;
                        w_hold_valid_nx = 1'b0;
                        w_tx_nx         = 1'b0;
                        w_state_nx      = ST_START;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state      <= ST_IDLE;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_hold_data  <= w_hold_data_nx;
            r_hold_valid <= w_hold_valid_nx;
            r_shift      <= w_shift_nx;
            r_cnt        <= w_cnt_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_tx         <= w_tx_nx;
            r_done       <= w_done_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_transmitter
// Purpose  : Self-checking bench for uart_apb_transmitter (CLKS_PER_BIT = 4).
//            A frame-timeline reference model is compared with the DUT
//            outputs on every cycle. Directed checks with literal expected
//            values cover reset, a single frame, back-to-back frames,
//            address decode, a reset in the middle of a frame, and serial
//            decode of a transmitted byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_transmitter;

    localparam int CPB = 4;

    logic       PCLK    = 1'b0;
    logic       PRESET  = 1'b0;
    logic       PSEL1   = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE  = 1'b0;
    logic [7:0] PADDR   = 8'h00;
    logic [7:0] PWDATA  = 8'h00;
    logic       PREADY;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    uart_apb_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL1     (PSEL1),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model. A frame is treated as a timeline of 10*CPB cycles
    // that starts at the load edge. The model also holds at most one
    // pending byte.
    // ------------------------------------------------------------------
    bit         chk_en = 1'b0;
    bit         m_hv   = 1'b0;
    logic [7:0] m_hold = 8'h00;
    bit         m_act  = 1'b0;
    logic [7:0] m_frame = 8'h00;
    int         m_t    = 0;
    bit         m_done = 1'b0;

    always @(posedge PCLK) begin
        bit acc;
        acc = PSEL1 && PENABLE && PWRITE && PADDR[7] && !m_hv;
        if (PRESET) begin
            m_hv   = 1'b0;
            m_act  = 1'b0;
            m_t    = 0;
            m_done = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_act) begin
                m_t++;
                if (m_t == 10 * CPB) begin
                    m_done = 1'b1;
                    if (m_hv) begin
                        m_frame = m_hold;
                        m_t     = 0;
                        m_hv    = 1'b0;
                    end else begin
                        m_act = 1'b0;
                    end
                end
            end else if (m_hv) begin
                m_act   = 1'b1;
                m_frame = m_hold;
                m_t     = 0;
                m_hv    = 1'b0;
            end
            if (acc) begin
                m_hv   = 1'b1;
                m_hold = PWDATA;
            end
        end
    end

    function automatic logic m_tx();
        int idx;
        if (!m_act) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_frame[idx-1];
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Compare process and history recorder (runs at the falling edge).
    // ------------------------------------------------------------------
    int   cyc      = 0;
    int   done_cnt = 0;
    int   done_at [0:63];
    logic tx_hist  [0:8191];
    logic busy_hist[0:8191];

    always @(negedge PCLK) begin
        if (chk_en) begin
            check("cyc_tx_serial", tx_serial, m_tx());
            check("cyc_tx_busy",   tx_busy,   m_act | m_hv);
            check("cyc_tx_done",   tx_done,   m_done);
            check("cyc_pready",    PREADY,    !m_hv);
            if (cyc < 8192) begin
                tx_hist[cyc]   = tx_serial;
                busy_hist[cyc] = tx_busy;
            end
            if (tx_done === 1'b1) begin
                if (done_cnt < 64) done_at[done_cnt] = cyc;
                done_cnt++;
            end
            cyc++;
        end
    end

    function automatic logic hist_tx(input int i);
        if (i < 0 || i >= 8192 || i >= cyc) return 1'bx;
        return tx_hist[i];
    endfunction

    function automatic logic hist_busy(input int i);
        if (i < 0 || i >= 8192 || i >= cyc) return 1'bx;
        return busy_hist[i];
    endfunction

    // First cycle at or after 'from' where the line is low.
    function automatic int find_fall(input int from);
        for (int i = from; i < cyc && i < 8192; i++)
            if (tx_hist[i] === 1'b0) return i;
        return -1;
    endfunction

    // Sample each data bit at the middle of its bit period.
    function automatic logic [7:0] decode(input int f);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = hist_tx(f + (b + 1) * CPB + CPB / 2);
        return r;
    endfunction

    // Every stimulus task starts and ends 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #2;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output int waits);
        waits   = 0;
        PSEL1   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = a;
        PWDATA  = d;
        tick(1);
        PENABLE = 1'b1;
        while (PREADY !== 1'b1 && waits < 300) begin
            tick(1);
            waits++;
        end
        if (waits >= 300) fail_now("apb_write_pready");
        tick(1);
        PSEL1   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic wait_done_count(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt < target) fail_now("wait_tx_done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w, w1, w2, w3, mark, d0, f, lows, nbusy;
        logic [9:0] a5_levels;

        a5_levels = 10'b1101001010;   // bit k = line level during bit period k

        // ---------------- Reset with random APB traffic ----------------
        @(posedge PCLK);
        #2;
        PRESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            PSEL1   = 1'($urandom_range(0, 1));
            PENABLE = 1'($urandom_range(0, 1));
            PWRITE  = 1'($urandom_range(0, 1));
            PADDR   = 8'($urandom_range(0, 255));
            PWDATA  = 8'($urandom_range(0, 255));
            tick(1);
        end
        PRESET = 1'b0;
        PSEL1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("reset_tx_serial", tx_serial, 1);
        check("reset_pready",    PREADY,    1);
        check("reset_tx_busy",   tx_busy,   0);
        check("reset_tx_done",   tx_done,   0);
        tick(8);
        check("reset_no_frame_busy", tx_busy, 0);
        check("reset_no_frame_done", done_cnt, 0);

        // ---------------- Single write 0xA5 ----------------
        mark = cyc;
        d0   = done_cnt;
        apb_write(8'h80, 8'hA5, w);
        check("a5_waits", w, 0);
        wait_done_count(d0 + 1, 100);
        tick(3);
        f = find_fall(mark);
        if (f < 0) begin
            fail_now("a5_find_start");
        end else begin
            for (int k = 0; k < 10; k++)
                check($sformatf("a5_bit%0d", k), hist_tx(f + k * CPB + CPB / 2), a5_levels[k]);
            check("a5_frame_len", done_at[d0] - f, 40);
            check("a5_busy_before_done", hist_busy(done_at[d0] - 1), 1);
            check("a5_busy_after_done", hist_busy(done_at[d0] + 1), 0);
        end
        check("a5_done_count", done_cnt - d0, 1);

        // ---------------- Back-to-back writes ----------------
        tick(4);
        mark = cyc;
        d0   = done_cnt;
        apb_write(8'h80, 8'h55, w1);
        apb_write(8'h80, 8'h0F, w2);
        apb_write(8'h80, 8'hF0, w3);
        check("b2b_waits1", w1, 0);
        check("b2b_waits2", w2, 0);
        check("b2b_waits3", w3, 38);
        wait_done_count(d0 + 3, 200);
        tick(3);
        f = find_fall(mark);
        if (f < 0 || done_cnt < d0 + 3) begin
            fail_now("b2b_frames");
        end else begin
            check("b2b_first_len", done_at[d0] - f, 40);
            check("b2b_gap12", done_at[d0 + 1] - done_at[d0], 40);
            check("b2b_gap23", done_at[d0 + 2] - done_at[d0 + 1], 40);
            check("b2b_stop1", hist_tx(f + 39), 1);
            check("b2b_start2", hist_tx(f + 40), 0);
            check("b2b_start3", hist_tx(f + 80), 0);
            check("b2b_byte1", decode(f), 8'h55);
            check("b2b_byte2", decode(f + 40), 8'h0F);
            check("b2b_byte3", decode(f + 80), 8'hF0);
        end
        check("b2b_done_count", done_cnt - d0, 3);

        // ---------------- Decode: accesses that must be ignored ----------------
        tick(4);
        mark = cyc;
        apb_write(8'h00, 8'h77, w);                   // wrong address
        PSEL1 = 1'b1; PWRITE = 1'b0; PADDR = 8'h80;   // read
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL1 = 1'b0; PENABLE = 1'b0;
        PSEL1 = 1'b1; PWRITE = 1'b1; PADDR = 8'h80; PWDATA = 8'h99;  // setup only
        tick(3);
        PSEL1 = 1'b0; PWRITE = 1'b0;
        tick(20);
        nbusy = 0;
        lows  = 0;
        for (int i = mark; i < cyc; i++) begin
            if (hist_busy(i) !== 1'b0) nbusy++;
            if (hist_tx(i) !== 1'b1) lows++;
        end
        check("decode_busy_cycles", nbusy, 0);
        check("decode_tx_low_cycles", lows, 0);

        // ---------------- Reset mid-frame with a byte pending ----------------
        d0 = done_cnt;
        apb_write(8'h80, 8'h33, w);
        apb_write(8'h80, 8'hCC, w);
        tick(15);                                   // now inside data bit 3
        check("midrst_pending", PREADY, 0);
        PRESET = 1'b1;
        tick(1);
        PRESET = 1'b0;
        check("midrst_tx_serial", tx_serial, 1);
        check("midrst_pready",    PREADY,    1);
        check("midrst_tx_busy",   tx_busy,   0);
        mark = cyc;
        tick(100);
        lows = 0;
        for (int i = mark; i < cyc; i++)
            if (hist_tx(i) !== 1'b1) lows++;
        check("midrst_no_later_frame", lows, 0);
        check("midrst_no_done", done_cnt - d0, 0);

        // ---------------- Serial decode of a byte ----------------
        mark = cyc;
        d0   = done_cnt;
        apb_write(8'h80, 8'h3C, w);
        wait_done_count(d0 + 1, 100);
        tick(2);
        f = find_fall(mark);
        if (f < 0) begin
            fail_now("loop_find_start");
        end else begin
            check("loop_byte", decode(f), 8'h3C);
            check("loop_stop", hist_tx(f + 9 * CPB + CPB / 2), 1);
        end
        check("loop_done_count", done_cnt - d0, 1);

        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
